// File: rtl/iic_pkg.sv
// Shared I2C definitions: target FSM state encodings and bus-condition helpers.
package iic_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_DATA  = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;
    localparam logic [2:0] ST_RD_WAIT  = 3'd5;
    localparam logic [2:0] ST_RD_DATA  = 3'd6;
    localparam logic [2:0] ST_RD_ACK   = 3'd7;

    localparam logic [1:0] COND_NONE  = 2'd0;
    localparam logic [1:0] COND_START = 2'd1;
    localparam logic [1:0] COND_STOP  = 2'd2;

    // SDA moving while SCL is high is a bus condition, never data.
    function automatic logic [1:0] iic_cond(input logic scl_lvl,
                                            input logic sda_rise,
                                            input logic sda_fall);
        logic [1:0] c;
        c = COND_NONE;
        if (scl_lvl && sda_fall)      c = COND_START;
        else if (scl_lvl && sda_rise) c = COND_STOP;
        return c;
    endfunction

endpackage

// File: rtl/siic_ops_if.sv
// User-side byte handshake between the I2C target and the local logic.
interface siic_ops_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_first;
    logic       rd_req;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_nack;
    logic       stop_det;

    modport slave (
        output wr_valid, wr_data, wr_first, rd_req, rd_nack, stop_det,
        input  rd_valid, rd_data
    );

    modport master (
        input  wr_valid, wr_data, wr_first, rd_req, rd_nack, stop_det,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/iic_line_filter.sv
// Bus line conditioning: 2-FF synchronizer, majority-free glitch filter, edge strobes.
module iic_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0]            sync_q;
    logic [FILTER_LEN-1:0] hist;
    logic                  level_nxt;

    // Level only moves once the whole history window agrees.
    always_comb begin
        level_nxt = level;
        if (&hist)       level_nxt = 1'b1;
        else if (~|hist) level_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            hist   <= '1;
            level  <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pin};
            hist   <= FILTER_LEN'({hist, sync_q[1]});
            level  <= level_nxt;
            rise   <= level_nxt & ~level;
            fall   <= ~level_nxt & level;
        end
    end

endmodule

// File: rtl/siic_ops.sv
// I2C target: address decode, write-byte receive with ACK, read-byte transmit with clock stretching.
module siic_ops
    import iic_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    output logic       scl_o,
    output logic       scl_t,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_t,
    siic_ops_if.slave  bus
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk(clk), .rst(rst), .pin(scl_i), .level(scl_f), .rise(scl_rise), .fall(scl_fall)
    );

    iic_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk(clk), .rst(rst), .pin(sda_i), .level(sda_f), .rise(sda_rise), .fall(sda_fall)
    );

    logic [2:0] state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [6:0] shreg, shreg_nxt;
    logic [6:0] tx, tx_nxt;
    logic       rnw, rnw_nxt;
    logic       first, first_nxt;
    logic       sda_t_q, sda_t_nxt;
    logic       scl_t_q, scl_t_nxt;
    logic       wr_valid_q, wr_valid_nxt;
    logic [7:0] wr_data_q, wr_data_nxt;
    logic       wr_first_q, wr_first_nxt;
    logic       rd_req_q, rd_req_nxt;
    logic       rd_nack_q, rd_nack_nxt;
    logic       stop_det_q, stop_det_nxt;
    logic [1:0] cond;

    assign scl_o        = 1'b0;
    assign sda_o        = 1'b0;
    assign scl_t        = scl_t_q;
    assign sda_t        = sda_t_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_first = wr_first_q;
    assign bus.rd_req   = rd_req_q;
    assign bus.rd_nack  = rd_nack_q;
    assign bus.stop_det = stop_det_q;

    // Next-state and output decode; bus conditions override any SCL edge.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        tx_nxt       = tx;
        rnw_nxt      = rnw;
        first_nxt    = first;
        sda_t_nxt    = sda_t_q;
        scl_t_nxt    = scl_t_q;
        wr_valid_nxt = 1'b0;
        wr_data_nxt  = wr_data_q;
        wr_first_nxt = wr_first_q;
        rd_req_nxt   = 1'b0;
        rd_nack_nxt  = 1'b0;
        stop_det_nxt = 1'b0;
        cond         = iic_cond(scl_f, sda_rise, sda_fall);

        if (cond == COND_START) begin
            state_nxt   = ST_ADDR;
            bit_cnt_nxt = 3'd0;
            sda_t_nxt   = 1'b1;
            scl_t_nxt   = 1'b1;
        end else if (cond == COND_STOP) begin
            state_nxt    = ST_IDLE;
            sda_t_nxt    = 1'b1;
            scl_t_nxt    = 1'b1;
            stop_det_nxt = 1'b1;
        end else begin
            case (state)
                ST_ADDR: if (scl_rise) begin
                    shreg_nxt   = {shreg[5:0], sda_f};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_nxt = 3'd0;
                        if (shreg == SLAVE_ADDR) begin
                            rnw_nxt   = sda_f;
                            state_nxt = ST_ADDR_ACK;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                // sda_t doubles as the phase flag: released = waiting to drive.
                ST_ADDR_ACK: if (scl_fall) begin
                    if (sda_t_q) begin
                        sda_t_nxt = 1'b0;
                    end else begin
                        sda_t_nxt = 1'b1;
                        if (rnw) begin
                            state_nxt  = ST_RD_WAIT;
                            scl_t_nxt  = 1'b0;
                            rd_req_nxt = 1'b1;
                        end else begin
                            state_nxt   = ST_WR_DATA;
                            first_nxt   = 1'b1;
                            bit_cnt_nxt = 3'd0;
                        end
                    end
                end
                ST_WR_DATA: if (scl_rise) begin
                    shreg_nxt   = {shreg[5:0], sda_f};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_nxt  = 3'd0;
                        wr_valid_nxt = 1'b1;
                        wr_data_nxt  = {shreg, sda_f};
                        wr_first_nxt = first;
                        first_nxt    = 1'b0;
                        state_nxt    = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: if (scl_fall) begin
                    if (sda_t_q) begin
                        sda_t_nxt = 1'b0;
                    end else begin
                        sda_t_nxt = 1'b1;
                        state_nxt = ST_WR_DATA;
                    end
                end
                ST_RD_WAIT: if (bus.rd_valid) begin
                    tx_nxt      = bus.rd_data[6:0];
                    sda_t_nxt   = bus.rd_data[7];
                    bit_cnt_nxt = 3'd0;
                    state_nxt   = ST_RD_DATA;
                end
                // First cycle here still holds SCL so the MSB settles before release.
                ST_RD_DATA: begin
                    if (!scl_t_q) begin
                        scl_t_nxt = 1'b1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 3'd7) begin
                            sda_t_nxt   = 1'b1;
                            bit_cnt_nxt = 3'd0;
                            state_nxt   = ST_RD_ACK;
                        end else begin
                            sda_t_nxt   = tx[6];
                            tx_nxt      = {tx[5:0], 1'b0};
                            bit_cnt_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_f) begin
                            bit_cnt_nxt = 3'd1;
                        end else begin
                            rd_nack_nxt = 1'b1;
                            sda_t_nxt   = 1'b1;
                            state_nxt   = ST_IDLE;
                        end
                    end else if (scl_fall && bit_cnt == 3'd1) begin
                        bit_cnt_nxt = 3'd0;
                        scl_t_nxt   = 1'b0;
                        rd_req_nxt  = 1'b1;
                        state_nxt   = ST_RD_WAIT;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 7'd0;
            tx         <= 7'd0;
            rnw        <= 1'b0;
            first      <= 1'b0;
            sda_t_q    <= 1'b1;
            scl_t_q    <= 1'b1;
            wr_valid_q <= 1'b0;
            wr_data_q  <= 8'd0;
            wr_first_q <= 1'b0;
            rd_req_q   <= 1'b0;
            rd_nack_q  <= 1'b0;
            stop_det_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shreg      <= shreg_nxt;
            tx         <= tx_nxt;
            rnw        <= rnw_nxt;
            first      <= first_nxt;
            sda_t_q    <= sda_t_nxt;
            scl_t_q    <= scl_t_nxt;
            wr_valid_q <= wr_valid_nxt;
            wr_data_q  <= wr_data_nxt;
            wr_first_q <= wr_first_nxt;
            rd_req_q   <= rd_req_nxt;
            rd_nack_q  <= rd_nack_nxt;
            stop_det_q <= stop_det_nxt;
        end
    end

endmodule

// File: tb/tb_siic_ops.sv
// Directed bench for siic_ops: bit-banged I2C controller, user read model, scoreboard queues.
module tb_siic_ops;
    import iic_pkg::*;

    localparam int unsigned Q = 8;
    localparam int unsigned H = 16;

    logic clk = 1'b0;
    logic rst;
    logic ctrl_scl, ctrl_sda;
    logic scl_o, scl_t, sda_o, sda_t;
    logic scl_bus, sda_bus;

    assign scl_bus = ctrl_scl & scl_t;
    assign sda_bus = ctrl_sda & sda_t;

    siic_ops_if bus_if ();

    siic_ops #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .clk(clk), .rst(rst),
        .scl_i(scl_bus), .scl_o(scl_o), .scl_t(scl_t),
        .sda_i(sda_bus), .sda_o(sda_o), .sda_t(sda_t),
        .bus(bus_if.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_wr = 0, n_rdreq = 0, n_nack = 0, n_stop = 0;
    int rd_cd = 0;
    int max_wait = 0;
    bit auto_rd = 1'b1;
    logic [8:0] exp_wr[$];
    logic [7:0] rd_src[$];
    logic [7:0] exp_rd[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs, score write bytes, run the user read-side model.
    task automatic tick();
        logic [8:0] e;
        @(posedge clk);
        #1;
        if (bus_if.wr_valid) begin
            n_wr++;
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", 32'(bus_if.wr_valid), 32'd0);
            end else begin
                e = exp_wr.pop_front();
                check("wr_byte", 32'({bus_if.wr_first, bus_if.wr_data}), 32'(e));
            end
        end
        bus_if.rd_valid = 1'b0;
        if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) begin
                check("stretch_held", 32'(scl_t), 32'd0);
                bus_if.rd_valid = 1'b1;
                bus_if.rd_data  = (rd_src.size() != 0) ? rd_src.pop_front() : 8'hFF;
            end
        end
        if (bus_if.rd_req) begin
            n_rdreq++;
            if (auto_rd) rd_cd = 40;
        end
        if (bus_if.rd_nack)  n_nack++;
        if (bus_if.stop_det) n_stop++;
    endtask

    task automatic wait_n(input int unsigned n);
        repeat (n) tick();
    endtask

    task automatic raise_scl();
        int n = 0;
        ctrl_scl = 1'b1;
        tick();
        while (scl_bus !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        if (n > max_wait) max_wait = n;
        if (n >= 3000) check("scl_release_timeout", 32'(scl_bus), 32'd1);
    endtask

    task automatic write_bit(input logic b);
        wait_n(Q); ctrl_sda = b; wait_n(Q);
        raise_scl(); wait_n(H);
        ctrl_scl = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_n(Q); ctrl_sda = 1'b1; wait_n(Q);
        raise_scl(); wait_n(Q);
        b = sda_bus;
        wait_n(Q);
        ctrl_scl = 1'b0;
    endtask

    task automatic start_cond();
        wait_n(Q); ctrl_sda = 1'b1; wait_n(Q);
        raise_scl(); wait_n(Q);
        ctrl_sda = 1'b0; wait_n(Q);
        ctrl_scl = 1'b0;
    endtask

    task automatic stop_cond();
        wait_n(Q); ctrl_sda = 1'b0; wait_n(Q);
        raise_scl(); wait_n(Q);
        ctrl_sda = 1'b1; wait_n(H);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic bt;
        for (int i = 7; i >= 0; i--) begin
            read_bit(bt);
            d[i] = bt;
        end
        write_bit(nack);
    endtask

    logic       ack;
    logic [7:0] d;
    logic [7:0] e8;
    int b_wr, b_rq, b_nk, b_st;

    initial begin
        ctrl_scl = 1'b1;
        ctrl_sda = 1'b1;
        bus_if.rd_valid = 1'b0;
        bus_if.rd_data  = 8'h00;
        rst = 1'b1;
        wait_n(3);
        check("rst_scl_t",    32'(scl_t), 32'd1);
        check("rst_sda_t",    32'(sda_t), 32'd1);
        check("rst_wr_valid", 32'(bus_if.wr_valid), 32'd0);
        check("rst_wr_data",  32'(bus_if.wr_data), 32'd0);
        check("rst_wr_first", 32'(bus_if.wr_first), 32'd0);
        check("rst_rd_req",   32'(bus_if.rd_req), 32'd0);
        check("rst_rd_nack",  32'(bus_if.rd_nack), 32'd0);
        check("rst_stop_det", 32'(bus_if.stop_det), 32'd0);
        check("rst_const_lo", 32'({scl_o, sda_o}), 32'd0);
        rst = 1'b0;
        wait_n(20);

        // Write 0x50/W, 0xA5, 0x3C, STOP.
        b_wr = n_wr; b_st = n_stop;
        exp_wr.push_back({1'b1, 8'hA5});
        exp_wr.push_back({1'b0, 8'h3C});
        start_cond();
        write_byte(8'hA0, ack); check("w_addr_ack", 32'(ack), 32'd0);
        write_byte(8'hA5, ack); check("w_b0_ack",   32'(ack), 32'd0);
        write_byte(8'h3C, ack); check("w_b1_ack",   32'(ack), 32'd0);
        stop_cond();
        check("w_wr_count",   32'(n_wr - b_wr), 32'd2);
        check("w_stop_count", 32'(n_stop - b_st), 32'd1);

        // Wrong address is ignored; the next START with the right one is answered.
        b_wr = n_wr;
        start_cond();
        write_byte(8'hA2, ack); check("bad_addr_nack", 32'(ack), 32'd1);
        write_byte(8'h99, ack); check("bad_addr_data_nack", 32'(ack), 32'd1);
        start_cond();
        write_byte(8'hA0, ack); check("good_addr_ack", 32'(ack), 32'd0);
        stop_cond();
        check("bad_addr_no_wr", 32'(n_wr - b_wr), 32'd0);

        // Read two bytes with a 40-cycle user delay each; ACK then NACK.
        b_rq = n_rdreq; b_nk = n_nack; b_st = n_stop;
        max_wait = 0;
        rd_src.push_back(8'hC3); exp_rd.push_back(8'hC3);
        rd_src.push_back(8'h5A); exp_rd.push_back(8'h5A);
        start_cond();
        write_byte(8'hA1, ack); check("r_addr_ack", 32'(ack), 32'd0);
        read_byte(d, 1'b0); e8 = exp_rd.pop_front(); check("r_byte0", 32'(d), 32'(e8));
        read_byte(d, 1'b1); e8 = exp_rd.pop_front(); check("r_byte1", 32'(d), 32'(e8));
        stop_cond();
        check("r_rdreq_count", 32'(n_rdreq - b_rq), 32'd2);
        check("r_nack_count",  32'(n_nack - b_nk), 32'd1);
        check("r_stop_count",  32'(n_stop - b_st), 32'd1);
        check("r_stretched",   32'(max_wait >= 30), 32'd1);

        // Write one byte, repeated START, then read.
        b_rq = n_rdreq; b_st = n_stop; b_wr = n_wr;
        exp_wr.push_back({1'b1, 8'h77});
        rd_src.push_back(8'h96); exp_rd.push_back(8'h96);
        start_cond();
        write_byte(8'hA0, ack); check("rs_waddr_ack", 32'(ack), 32'd0);
        write_byte(8'h77, ack); check("rs_wdata_ack", 32'(ack), 32'd0);
        start_cond();
        write_byte(8'hA1, ack); check("rs_raddr_ack", 32'(ack), 32'd0);
        read_byte(d, 1'b1); e8 = exp_rd.pop_front(); check("rs_rbyte", 32'(d), 32'(e8));
        check("rs_no_stop_yet", 32'(n_stop - b_st), 32'd0);
        check("rs_rdreq",       32'(n_rdreq - b_rq), 32'd1);
        check("rs_wr_count",    32'(n_wr - b_wr), 32'd1);
        stop_cond();
        check("rs_final_stop",  32'(n_stop - b_st), 32'd1);

        // One-cycle SDA glitch while SCL is high must not register as START/STOP.
        b_st = n_stop;
        wait_n(20);
        ctrl_sda = 1'b0;
        tick();
        ctrl_sda = 1'b1;
        wait_n(20);
        check("glitch_no_stop",  32'(n_stop - b_st), 32'd0);
        check("glitch_idle",     32'(dut.state), 32'(ST_IDLE));
        ctrl_scl = 1'b0;
        wait_n(H);
        write_byte(8'hA0, ack); check("glitch_no_start_ack", 32'(ack), 32'd1);
        stop_cond();
        check("glitch_then_stop", 32'(n_stop - b_st), 32'd1);

        // Reset while the target is stretching SCL in RD_WAIT.
        auto_rd = 1'b0;
        start_cond();
        write_byte(8'hA1, ack); check("rst_rd_addr_ack", 32'(ack), 32'd0);
        wait_n(20);
        check("pre_rst_stretch", 32'(scl_t), 32'd0);
        check("pre_rst_state",   32'(dut.state), 32'(ST_RD_WAIT));
        rst = 1'b1;
        tick();
        check("mid_rst_scl_t", 32'(scl_t), 32'd1);
        check("mid_rst_sda_t", 32'(sda_t), 32'd1);
        check("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
        rst = 1'b0;
        ctrl_sda = 1'b1;
        ctrl_scl = 1'b1;
        wait_n(40);
        auto_rd = 1'b1;

        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/siic_ops.md
SIIC_OPS -- requirements
Module: siic_ops

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50: 7-bit I2C address this target answers.
REQ-002 Parameter FILTER_LEN, default 3: number of consecutive equal synchronized samples needed to accept an SCL/SDA level change.
REQ-003 clk  input  1  core clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 scl_i  input  1  bus SCL level.
REQ-006 scl_o  output  1  constant 0; drive is done via scl_t.
REQ-007 scl_t  output  1  SCL tristate: 1=release, 0=pull low (clock stretch).
REQ-008 sda_i  input  1  bus SDA level.
REQ-009 sda_o  output  1  constant 0; drive is done via sda_t.
REQ-010 sda_t  output  1  SDA tristate: 1=release, 0=pull low.
REQ-011 wr_valid  output  1  one-cycle pulse: a byte was received from the controller.
REQ-012 wr_data  output  8  received byte, MSB first on the wire; held until the next wr_valid.
REQ-013 wr_first  output  1  qualifies wr_valid: first data byte after an address match.
REQ-014 rd_req  output  1  one-cycle pulse: the controller needs the next read byte.
REQ-015 rd_valid  input  1  user supplies rd_data; sampled only while in RD_WAIT.
REQ-016 rd_data  input  8  byte to transmit, captured in the cycle rd_valid is sampled high.
REQ-017 rd_nack  output  1  one-cycle pulse: the controller NACKed a read byte.
REQ-018 stop_det  output  1  one-cycle pulse on every detected STOP.

Function
REQ-019 Each of scl_i/sda_i passes through a 2-FF synchronizer, then a FILTER_LEN-deep glitch filter; all decoding uses the filtered levels (scl_f, sda_f).
REQ-020 SCL rise/fall = one-cycle edge strobe on scl_f; START = sda_f falls while scl_f high; STOP = sda_f rises while scl_f high.
REQ-021 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_WAIT, RD_DATA, RD_ACK.
REQ-022 START in any state -> ADDR, bit count cleared, sda_t=1, scl_t=1; this covers repeated START.
REQ-023 STOP in any state -> IDLE, sda_t=1, scl_t=1, stop_det pulse.
REQ-024 START/STOP take priority over an SCL edge in the same cycle.
REQ-025 ADDR: shift sda_f on each SCL rise; after the 8th rise compare bits[7:1] with SLAVE_ADDR and latch rnw=bit0.
REQ-026 On mismatch -> IDLE, bus untouched until the next START.
REQ-027 On match: drive SDA low at the next SCL fall (ADDR_ACK), release at the following fall; then go to RD_WAIT if rnw=1, else WR_DATA.
REQ-028 WR_DATA: shift 8 bits on SCL rises; at the 8th rise pulse wr_valid with wr_data.
REQ-029 wr_first=1 only for the first byte after ADDR_ACK.
REQ-030 WR_ACK: drive SDA low from the next SCL fall until the fall after it, then return to WR_DATA; every write byte is ACKed.
REQ-031 RD_WAIT: entered on an SCL fall; scl_t=0 (stretch) from the entry cycle; rd_req pulses exactly once, in the entry cycle.
REQ-032 RD_WAIT with rd_valid=1: capture rd_data, set sda_t to its MSB, release SCL one cycle later, -> RD_DATA; stretch lasts indefinitely otherwise.
REQ-033 RD_DATA: present the next bit at each SCL fall; after the 8th bit's fall set sda_t=1 and -> RD_ACK.
REQ-034 RD_ACK: sample sda_f at the SCL rise. 0 -> at the next fall enter RD_WAIT. 1 -> pulse rd_nack, -> IDLE with SDA released.

Reset
REQ-035 rst: state IDLE, sda_t=1, scl_t=1, wr_valid/rd_req/rd_nack/stop_det=0, wr_data=0, wr_first=0.
REQ-036 rst: filters preset to 1 (idle bus); asserting rst mid-transfer releases both lines in the next cycle.

Structure
REQ-037 State encodings and edge/condition helper constants live in a shared iic_pkg, used alongside the I2C controller engine.
REQ-038 One sub-module, iic_line_filter (synchronizer + glitch filter + edge strobes), is instantiated twice, once for SCL and once for SDA.

Verification
REQ-039 Controller writes addr 0x50/W, bytes 0xA5,0x3C, STOP -> ACK on 3 bytes; wr_valid x2 with data 0xA5 (wr_first=1), then 0x3C (wr_first=0); one stop_det.
REQ-040 Addr 0x51/W -> no ACK, no wr_valid; a following START with 0x50/W is ACKed.
REQ-041 0x50/R; user asserts rd_valid 40 cycles after rd_req with 0xC3; controller ACKs then NACKs second byte 0x5A -> SCL held low during each wait; bits 11000011, 01011010; one rd_nack.
REQ-042 Write 0x50/W + 1 byte, repeated START, 0x50/R -> rnw switches, rd_req issued; no stop_det before the final STOP.
REQ-043 1-cycle SDA glitch with SCL high, FILTER_LEN=3 -> no START/STOP detected.
REQ-044 rst during RD_WAIT stretch -> scl_t=1 and sda_t=1 the next cycle; state IDLE.
